// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Burst and stall counters are 8 bits and saturate.
  localparam int unsigned CNT_W = 8;

  // Pointer / index width for the round-robin picker (up to 8 requesters).
  localparam int unsigned PTR_W = 3;

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin picker: first set request at or above ptr_i, wrapping to 0.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o
);

  logic [PTR_W:0] cand;
  logic           found;

  // Walk candidates ptr, ptr+1, ... modulo NUM_REQ and take the first request.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (cand == (PTR_W+1)'(j))) begin
          grant_o[j] = 1'b1;
          idx_o      = PTR_W'(j);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing the UART transmit FIFO write port.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned STALL_LIMIT = 32
) (
  input  logic                           SysClk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             ReqValid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   ReqData,
  input  logic [NUM_REQ-1:0]             ReqLast,
  output logic [NUM_REQ-1:0]             ReqReady,
  input  logic                           TxFull,
  output logic                           TxWrite,
  output logic [DATA_BITS-1:0]           TxData,
  output logic [NUM_REQ-1:0]             Grant,
  output logic                           Busy
);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q;
  logic [CNT_W-1:0]     burst_q, burst_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [PTR_W-1:0]     pick_idx;

  logic                 owner_valid;
  logic                 owner_last;
  logic [DATA_BITS-1:0] owner_data;
  logic                 xfer;
  logic                 rel_c;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (ReqValid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Select the current owner's valid, last and data lanes.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_valid = ReqValid[i];
        owner_last  = ReqLast[i];
        owner_data  = ReqData[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Transfer qualification, saturating counter increments and release decision.
  always_comb begin
    xfer    = (state_q == BURST) && owner_valid && !TxFull;
    burst_d = (burst_q == '1) ? burst_q : burst_q + CNT_W'(1);
    stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
    ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    rel_c   = 1'b0;
    if (state_q == BURST) begin
      if (xfer) begin
        rel_c = owner_last || (burst_d >= CNT_W'(MAX_BURST));
      end else begin
        rel_c = (stall_d >= CNT_W'(STALL_LIMIT));
      end
    end
  end

  // FIFO write port and handshake follow the live inputs so TxFull is honoured same cycle.
  assign TxWrite  = xfer;
  assign TxData   = xfer ? owner_data : '0;
  assign ReqReady = xfer ? grant_q : '0;
  assign Grant    = grant_q;
  assign Busy     = busy_q;

  // Arbitration FSM with burst/stall counters and round-robin pointer.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|ReqValid) begin
            state_q <= BURST;
            grant_q <= pick_grant;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
            burst_q <= '0;
            stall_q <= '0;
          end
        end
        BURST: begin
          if (xfer) begin
            burst_q <= burst_d;
            stall_q <= '0;
          end else begin
            stall_q <= stall_d;
          end
          if (rel_c) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed cycle table plus randomized run against a reference model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DB    = 8;
  localparam int MAXB  = 4;
  localparam int STALL = 32;

  logic            SysClk;
  logic            Rst;
  logic [N-1:0]    ReqValid;
  logic [N*DB-1:0] ReqData;
  logic [N-1:0]    ReqLast;
  logic [N-1:0]    ReqReady;
  logic            TxFull;
  logic            TxWrite;
  logic [DB-1:0]   TxData;
  logic [N-1:0]    Grant;
  logic            Busy;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DATA_BITS   (DB),
    .MAX_BURST   (MAXB),
    .STALL_LIMIT (STALL)
  ) dut (
    .SysClk   (SysClk),
    .Rst      (Rst),
    .ReqValid (ReqValid),
    .ReqData  (ReqData),
    .ReqLast  (ReqLast),
    .ReqReady (ReqReady),
    .TxFull   (TxFull),
    .TxWrite  (TxWrite),
    .TxData   (TxData),
    .Grant    (Grant),
    .Busy     (Busy)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  // Directed cycle vectors: inputs for the cycle and the outputs expected during it.
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic        full;
    logic [31:0] d;
    logic [3:0]  g;
    logic        busy;
    logic        wr;
    logic [7:0]  td;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic full, input logic [31:0] d, input logic [3:0] g,
                              input logic busy, input logic wr, input logic [7:0] td);
    vec_t x;
    x.rst = rst; x.v = v; x.l = l; x.full = full; x.d = d;
    x.g = g; x.busy = busy; x.wr = wr; x.td = td;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at step %0d: got %0h, expected %0h", name, idx, act, exp);
  endtask

  // Reference model: owner (-1 when idle), rotation pointer, bytes sent, idle cycles.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_bytes = 0;
  int m_idle  = 0;

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit moved, done;
    int r;
    if (Rst) begin
      m_owner = -1; m_ptr = 0; m_bytes = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (m_owner < 0 && ReqValid[r]) begin
          m_owner = r; m_bytes = 0; m_idle = 0;
        end
      end
    end else begin
      moved = ReqValid[m_owner] && !TxFull;
      if (moved) begin
        m_bytes = (m_bytes < 255) ? m_bytes + 1 : 255;
        m_idle  = 0;
        done    = ReqLast[m_owner] || (m_bytes >= MAXB);
      end else begin
        m_idle = (m_idle < 255) ? m_idle + 1 : 255;
        done   = (m_idle >= STALL);
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // Compare all outputs against what the model predicts for the current inputs.
  task automatic check_model(input int idx);
    logic       e_wr;
    logic [7:0] e_td;
    logic [3:0] e_g;
    e_g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e_wr = (m_owner >= 0) && ReqValid[m_owner] && !TxFull;
    e_td = e_wr ? ReqData[m_owner*DB +: DB] : 8'h00;
    check("rand_Grant",    idx, 32'(Grant),    32'(e_g));
    check("rand_Busy",     idx, 32'(Busy),     32'(m_owner >= 0));
    check("rand_TxWrite",  idx, 32'(TxWrite),  32'(e_wr));
    check("rand_TxData",   idx, 32'(TxData),   32'(e_td));
    check("rand_ReqReady", idx, 32'(ReqReady), e_wr ? 32'(e_g) : 32'd0);
  endtask

  int full_run;

  initial begin
    Rst = 1'b1; ReqValid = '0; ReqData = '0; ReqLast = '0; TxFull = 1'b0;

    // Single requester 1: three-byte message, then pointer check (1 and 2 ready -> 2 wins).
    add(0, 4'b0010, 4'b0000, 0, 32'h0000_A100, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0010, 4'b0000, 0, 32'h0000_A100, 4'b0010, 1, 1, 8'hA1);
    add(0, 4'b0010, 4'b0000, 0, 32'h0000_A200, 4'b0010, 1, 1, 8'hA2);
    add(0, 4'b0010, 4'b0010, 0, 32'h0000_A300, 4'b0010, 1, 1, 8'hA3);
    add(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0110, 4'b0110, 0, 32'h00C2_B100, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0110, 4'b0110, 0, 32'h00C2_B100, 4'b0100, 1, 1, 8'hC2);
    add(0, 4'b0010, 4'b0010, 0, 32'h0000_B100, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0010, 4'b0010, 0, 32'h0000_B100, 4'b0010, 1, 1, 8'hB1);
    add(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 0, 8'h00);
    // Requesters 0 and 2 valid from reset: 0 finishes, bubble, then 2.
    add(1, 4'b0101, 4'b0000, 0, 32'h0020_0010, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0101, 4'b0000, 0, 32'h0020_0010, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0101, 4'b0000, 0, 32'h0020_0010, 4'b0001, 1, 1, 8'h10);
    add(0, 4'b0101, 4'b0001, 0, 32'h0020_0011, 4'b0001, 1, 1, 8'h11);
    add(0, 4'b0100, 4'b0000, 0, 32'h0020_0000, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0100, 4'b0000, 0, 32'h0020_0000, 4'b0100, 1, 1, 8'h20);
    add(0, 4'b0100, 4'b0100, 0, 32'h0021_0000, 4'b0100, 1, 1, 8'h21);
    add(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 0, 8'h00);
    // Requester 3 streams 10 bytes without Last; forced release every 4, requester 1 in between.
    add(0, 4'b1010, 4'b0010, 0, 32'h3000_B000, 4'b0000, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++)
      add(0, 4'b1010, 4'b0010, 0, {8'(8'h30 + i), 24'h00_B000}, 4'b1000, 1, 1, 8'(8'h30 + i));
    add(0, 4'b1010, 4'b0010, 0, 32'h3400_B000, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b1010, 4'b0010, 0, 32'h3400_B000, 4'b0010, 1, 1, 8'hB0);
    add(0, 4'b1000, 4'b0000, 0, 32'h3400_0000, 4'b0000, 0, 0, 8'h00);
    for (int i = 4; i < 8; i++)
      add(0, 4'b1000, 4'b0000, 0, {8'(8'h30 + i), 24'h0}, 4'b1000, 1, 1, 8'(8'h30 + i));
    add(0, 4'b1000, 4'b0000, 0, 32'h3800_0000, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b1000, 4'b0000, 0, 32'h3800_0000, 4'b1000, 1, 1, 8'h38);
    add(0, 4'b1000, 4'b1000, 0, 32'h3900_0000, 4'b1000, 1, 1, 8'h39);
    add(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 0, 8'h00);
    // TxFull held 40 cycles: release after 32 stalls, pointer moves past 2 so 3 wins.
    add(0, 4'b0100, 4'b0000, 1, 32'h0055_0000, 4'b0000, 0, 0, 8'h00);
    for (int i = 0; i < 32; i++)
      add(0, 4'b1100, 4'b0000, 1, 32'h7755_0000, 4'b0100, 1, 0, 8'h00);
    add(0, 4'b1100, 4'b0000, 1, 32'h7755_0000, 4'b0000, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++)
      add(0, 4'b1100, 4'b0000, 1, 32'h7755_0000, 4'b1000, 1, 0, 8'h00);
    add(0, 4'b1100, 4'b1000, 0, 32'h7755_0000, 4'b1000, 1, 1, 8'h77);
    add(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 0, 0, 8'h00);
    // Rst mid-burst after two bytes of a 4-byte message; re-arbitration from requester 0.
    add(0, 4'b0100, 4'b0100, 0, 32'h0099_0000, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0100, 4'b0100, 0, 32'h0099_0000, 4'b0100, 1, 1, 8'h99);
    add(0, 4'b0010, 4'b0000, 0, 32'h0000_E000, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b0010, 4'b0000, 0, 32'h0000_E000, 4'b0010, 1, 1, 8'hE0);
    add(0, 4'b0010, 4'b0000, 0, 32'h0000_E100, 4'b0010, 1, 1, 8'hE1);
    add(1, 4'b0010, 4'b0000, 0, 32'h0000_E200, 4'b0010, 1, 1, 8'hE2);
    add(0, 4'b1010, 4'b0000, 0, 32'h3C00_E200, 4'b0000, 0, 0, 8'h00);
    add(0, 4'b1010, 4'b0000, 0, 32'h3C00_E200, 4'b0010, 1, 1, 8'hE2);
    add(1, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0010, 1, 0, 8'h00);
    // All four valid with single-byte messages: grants rotate 0,1,2,3,0 with bubbles.
    for (int i = 0; i < 5; i++) begin
      add(0, 4'b1111, 4'b1111, 0, 32'h4342_4140, 4'b0000, 0, 0, 8'h00);
      add(0, 4'b1111, 4'b1111, 0, 32'h4342_4140, 4'(1 << (i % 4)), 1, 1, 8'(8'h40 + (i % 4)));
    end

    // Hold reset across two edges, then check the reset state.
    @(negedge SysClk);
    model_step();
    @(negedge SysClk);
    Rst = 1'b0;
    #1;
    check("rst_Grant",    -1, 32'(Grant),    32'd0);
    check("rst_Busy",     -1, 32'(Busy),     32'd0);
    check("rst_TxWrite",  -1, 32'(TxWrite),  32'd0);
    check("rst_TxData",   -1, 32'(TxData),   32'd0);
    check("rst_ReqReady", -1, 32'(ReqReady), 32'd0);
    model_step();
    @(negedge SysClk);

    // Apply the directed table one row per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      Rst = vecs[i].rst; ReqValid = vecs[i].v; ReqLast = vecs[i].l;
      TxFull = vecs[i].full; ReqData = vecs[i].d;
      #1;
      check("Grant",    i, 32'(Grant),    32'(vecs[i].g));
      check("Busy",     i, 32'(Busy),     32'(vecs[i].busy));
      check("TxWrite",  i, 32'(TxWrite),  32'(vecs[i].wr));
      check("TxData",   i, 32'(TxData),   32'(vecs[i].td));
      check("ReqReady", i, 32'(ReqReady), vecs[i].wr ? 32'(vecs[i].g) : 32'd0);
      model_step();
      @(negedge SysClk);
    end

    // Randomized traffic against the reference model.
    Rst = 1'b1; ReqValid = '0; ReqLast = '0; TxFull = 1'b0; ReqData = '0;
    #1;
    model_step();
    @(negedge SysClk);
    full_run = 0;
    for (int c = 0; c < 3000; c++) begin
      Rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < N; b++) begin
        ReqValid[b] = ($urandom_range(0, 9) < 6);
        ReqLast[b]  = ($urandom_range(0, 9) < 3);
      end
      ReqData = $urandom();
      if (full_run > 0) begin
        TxFull = 1'b1;
        full_run--;
      end else if ($urandom_range(0, 49) == 0) begin
        TxFull   = 1'b1;
        full_run = int'($urandom_range(10, 45));
      end else begin
        TxFull = ($urandom_range(0, 9) < 2);
      end
      #1;
      check_model(c);
      model_step();
      @(negedge SysClk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
